mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-port access controller for the 16 x 8 data memory bank. It sequences every memory transaction so the bank sees exactly one access at a time, and shares the bank between the CPU datapath (port 0) and the debug/DMA loader (port 1) under round-robin arbitration. It returns read data and a one-cycle acknowledge to each requester. It sits between the execute stage and the memory bank and is the only driver of the bank's address, data and r_w pins.

## Interface
- ADDR_W, 4, memory address width (16 locations)
- DATA_W, 8, memory word width
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  target address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  last read result for the port
- mem_addr_in  out  ADDR_W  bank write address
- mem_addr_out  out  ADDR_W  bank read address
- mem_data_in  out  DATA_W  bank write data
- mem_data_out  in  DATA_W  bank read data (combinational from mem_addr_out)
- mem_r_w  out  1  bank control: 1 = read, 0 = write
- mem_enable  out  1  high only while an access is driven
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  port owning the current or last transaction

## Operation
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: if req0 or req1 is high, choose a winner and latch its we/addr/wdata into internal registers, set grant_id, go to ACCESS. Otherwise stay.
- Arbitration: a single request always wins. If both are high, the winner is the port opposite the last_grant pointer. last_grant resets to 1, so port 0 wins the first tie. last_grant updates to the winner when DONE is entered.
- ACCESS: mem_enable=1, mem_addr_in=mem_addr_out=latched addr, mem_data_in=latched wdata, mem_r_w = ~latched we. Go to DONE.
- DONE: on a read, mem_data_out is captured into the winner's rdata on the ACCESS->DONE edge. The winner's ack is high for this cycle only. mem_enable=0, mem_r_w=1. Go to IDLE unconditionally.
- The bank writes whenever r_w=0. mem_r_w is therefore 0 only in ACCESS with a latched write, and 1 in every other state and during reset.
- rdata of a port changes only on that port's reads. Writes and the other port's accesses leave it unchanged.
- Requesters hold req, we, addr and wdata stable until their ack. A req dropped before being latched is ignored. Once latched, the transaction completes and ack pulses even if req has dropped.
- Reset at any time: state goes to IDLE and the in-flight transaction is abandoned with no ack and no rdata update. If reset hits during ACCESS on a write, mem_r_w returns to 1 on that edge.

## Timing
- Reset values: ack0=ack1=0, rdata0=rdata1=0, mem_addr_in=mem_addr_out=0, mem_data_in=0, mem_r_w=1, mem_enable=0, busy=0, grant_id=0, state IDLE.
- Latency: req sampled high at edge E gives ACCESS during cycle E..E+1. ack and rdata are valid during cycle E+1..E+2.
- Throughput: one access per 3 cycles. A req held high in DONE is not re-accepted until IDLE, so there are no duplicate accesses.
- Both ports continuously requesting produce grants 0,1,0,1,… with one access every 3 cycles.
- mem_addr_* and mem_data_in hold their last values outside ACCESS. Only mem_r_w and mem_enable are forced idle.

## Test plan
- Reset, then port 0 reads addr 5 holding 8'hA3: ack0 pulses 2 cycles after req, rdata0=8'hA3, ack1 stays 0, mem_r_w never 0.
- Port 1 writes 8'h5C to addr 15, then port 1 reads addr 15: mem_r_w=0 for exactly one cycle (ACCESS), read returns 8'h5C, rdata0 unchanged.
- Both ports hold req from reset for 12 cycles: grants alternate 0,1,0,1, with an ack every 3 cycles and no two acks in the same cycle.
- Assert reset during ACCESS of a port 0 write to addr 3: no ack0, mem_r_w=1 after the edge, all outputs at reset values, next request serviced normally.
- Port 0 pulses req for one cycle while the FSM is busy with port 1: request is not latched and ack0 never pulses. Port 0 holding req in DONE is granted next after port 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin access controller for the 16 x 8 data memory bank.
// Serialises CPU (port 0) and loader (port 1) accesses as IDLE -> ACCESS -> DONE.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_r_w,
    output logic              mem_enable,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state_q, state_n;
    logic                last_grant_q, last_grant_n;
    logic                we_q, we_n;
    logic                ack0_n, ack1_n;
    logic [DATA_W-1:0]   rdata0_n, rdata1_n;
    logic [ADDR_W-1:0]   mem_addr_in_n, mem_addr_out_n;
    logic [DATA_W-1:0]   mem_data_in_n;
    logic                mem_r_w_n, mem_enable_n, busy_n, grant_id_n;
    logic                winner_c;

    // A lone request wins; on a tie the port opposite the last grant wins.
    assign winner_c = (req0 && req1) ? ~last_grant_q : req1;

    // Next state plus next value of every registered output.
    always_comb begin
        state_n        = state_q;
        last_grant_n   = last_grant_q;
        we_n           = we_q;
        ack0_n         = 1'b0;
        ack1_n         = 1'b0;
        rdata0_n       = rdata0;
        rdata1_n       = rdata1;
        mem_addr_in_n  = mem_addr_in;
        mem_addr_out_n = mem_addr_out;
        mem_data_in_n  = mem_data_in;
        mem_r_w_n      = 1'b1;
        mem_enable_n   = 1'b0;
        grant_id_n     = grant_id;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_n        = ACCESS;
                    grant_id_n     = winner_c;
                    we_n           = winner_c ? we1 : we0;
                    mem_addr_in_n  = winner_c ? addr1 : addr0;
                    mem_addr_out_n = winner_c ? addr1 : addr0;
                    mem_data_in_n  = winner_c ? wdata1 : wdata0;
                    mem_r_w_n      = winner_c ? ~we1 : ~we0;
                    mem_enable_n   = 1'b1;
                end
            end
            ACCESS: begin
                state_n      = DONE;
                last_grant_n = grant_id;
                if (grant_id) begin
                    ack1_n = 1'b1;
                    if (!we_q) rdata1_n = mem_data_out;
                end else begin
                    ack0_n = 1'b1;
                    if (!we_q) rdata0_n = mem_data_out;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            mem_addr_in  <= '0;
            mem_addr_out <= '0;
            mem_data_in  <= '0;
            mem_r_w      <= 1'b1;
            mem_enable   <= 1'b0;
            busy         <= 1'b0;
            grant_id     <= 1'b0;
        end else begin
            state_q      <= state_n;
            last_grant_q <= last_grant_n;
            we_q         <= we_n;
            ack0         <= ack0_n;
            ack1         <= ack1_n;
            rdata0       <= rdata0_n;
            rdata1       <= rdata1_n;
            mem_addr_in  <= mem_addr_in_n;
            mem_addr_out <= mem_addr_out_n;
            mem_data_in  <= mem_data_in_n;
            mem_r_w      <= mem_r_w_n;
            mem_enable   <= mem_enable_n;
            busy         <= busy_n;
            grant_id     <= grant_id_n;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 16 x 8 bank model.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [3:0] mem_addr_in, mem_addr_out;
    logic [7:0] mem_data_in, mem_data_out;
    logic       mem_r_w, mem_enable, busy, grant_id;
    logic       init_bank;
    logic [7:0] bank [16];

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr_in(mem_addr_in), .mem_addr_out(mem_addr_out),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_r_w(mem_r_w), .mem_enable(mem_enable), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Bank: combinational read, writes on any edge where r_w is low.
    assign mem_data_out = bank[mem_addr_out];
    always @(posedge clk) begin
        if (init_bank) begin
            for (int i = 0; i < 16; i++) bank[i] <= 8'h10 + 8'(i);
            bank[5] <= 8'hA3;
        end else if (!mem_r_w) begin
            bank[mem_addr_in] <= mem_data_in;
        end
    end

    typedef struct {
        bit         port;
        bit         we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_r0;
        logic [7:0] exp_r1;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drop_all();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    endtask

    // One single-port transaction: ack exactly 2 cycles after req is driven.
    task automatic do_txn(input vec_t v);
        int n = 0;
        int wr = 0;
        bit other = 0;
        bit got = 0;
        if (v.port) begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end
        while (!got && n < 10) begin
            tick();
            n++;
            if (!mem_r_w) wr++;
            if (v.port ? ack0 : ack1) other = 1;
            if (v.port ? ack1 : ack0) got = 1;
        end
        drop_all();
        chk("txn_latency", n, 2);
        chk("txn_rdata0", int'(rdata0), int'(v.exp_r0));
        chk("txn_rdata1", int'(rdata1), int'(v.exp_r1));
        chk("txn_write_cycles", wr, v.we ? 1 : 0);
        chk("txn_other_ack", int'(other), 0);
        chk("txn_grant_id", int'(grant_id), int'(v.port));
        tick();
    endtask

    initial begin
        int ack_cyc [$];
        int ack_id [$];
        int n;
        bit seen0;
        bit dbl;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 4'd5,  wdata: 8'h00, exp_r0: 8'hA3, exp_r1: 8'h00};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 4'd15, wdata: 8'h5C, exp_r0: 8'hA3, exp_r1: 8'h00};
        vecs[2] = '{port: 1'b1, we: 1'b0, addr: 4'd15, wdata: 8'h00, exp_r0: 8'hA3, exp_r1: 8'h5C};
        vecs[3] = '{port: 1'b0, we: 1'b1, addr: 4'd5,  wdata: 8'h11, exp_r0: 8'hA3, exp_r1: 8'h5C};
        vecs[4] = '{port: 1'b0, we: 1'b0, addr: 4'd5,  wdata: 8'h00, exp_r0: 8'h11, exp_r1: 8'h5C};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 4'd0,  wdata: 8'h00, exp_r0: 8'h11, exp_r1: 8'h10};
        vecs[6] = '{port: 1'b0, we: 1'b0, addr: 4'd15, wdata: 8'h00, exp_r0: 8'h5C, exp_r1: 8'h10};

        drop_all();
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        reset = 1'b1; init_bank = 1'b1;
        tick(); tick();
        reset = 1'b0; init_bank = 1'b0;

        chk("rst_ack0", int'(ack0), 0);
        chk("rst_ack1", int'(ack1), 0);
        chk("rst_rdata0", int'(rdata0), 0);
        chk("rst_rdata1", int'(rdata1), 0);
        chk("rst_mem_r_w", int'(mem_r_w), 1);
        chk("rst_mem_enable", int'(mem_enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant_id", int'(grant_id), 0);

        for (int i = 0; i < 7; i++) do_txn(vecs[i]);

        // Both ports requesting from reset: grants alternate, one ack per 3 cycles.
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        tick(); tick();
        reset = 1'b0;
        dbl = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ack0 && ack1) dbl = 1;
            if (ack0 || ack1) begin
                ack_cyc.push_back(c);
                ack_id.push_back(ack1 ? 1 : 0);
            end
        end
        drop_all();
        chk("rr_double_ack", int'(dbl), 0);
        chk("rr_ack_count", ack_cyc.size(), 4);
        if (ack_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("rr_ack_id", ack_id[k], k % 2);
                chk("rr_ack_cycle", ack_cyc[k], 2 + 3 * k);
            end
        end
        tick();
        chk("rr_rdata0", int'(rdata0), 8'h11);
        chk("rr_rdata1", int'(rdata1), 8'h12);

        // Reset lands while a port 0 write is in ACCESS.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'h77;
        tick();
        chk("abort_access_r_w", int'(mem_r_w), 0);
        chk("abort_access_en", int'(mem_enable), 1);
        reset = 1'b1;
        tick();
        chk("abort_ack0", int'(ack0), 0);
        chk("abort_mem_r_w", int'(mem_r_w), 1);
        chk("abort_mem_enable", int'(mem_enable), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rdata0", int'(rdata0), 0);
        chk("abort_rdata1", int'(rdata1), 0);
        chk("abort_addr_in", int'(mem_addr_in), 0);
        chk("abort_addr_out", int'(mem_addr_out), 0);
        chk("abort_data_in", int'(mem_data_in), 0);
        chk("abort_grant_id", int'(grant_id), 0);
        drop_all();
        reset = 1'b0;
        tick();
        chk("abort_ack0_after", int'(ack0), 0);
        do_txn('{port: 1'b1, we: 1'b0, addr: 4'd15, wdata: 8'h00, exp_r0: 8'h00, exp_r1: 8'h5C});

        // A one-cycle port 0 pulse while port 1 is busy is never latched.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd0;
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd4;
        tick();
        chk("pulse_ack1", int'(ack1), 1);
        req0 = 1'b0; req1 = 1'b0;
        seen0 = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack0) seen0 = 1;
        end
        chk("pulse_no_ack0", int'(seen0), 0);
        chk("pulse_rdata1", int'(rdata1), 8'h10);

        // Port 0 held through port 1's DONE is granted next, despite port 1 re-requesting.
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        tick();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd4;
        tick();
        chk("hold_ack1", int'(ack1), 1);
        n = 0;
        seen0 = 0;
        dbl = 0;
        while (!seen0 && n < 10) begin
            tick();
            n++;
            if (ack1) dbl = 1;
            if (ack0) seen0 = 1;
        end
        drop_all();
        chk("hold_ack0_delay", n, 3);
        chk("hold_no_ack1_between", int'(dbl), 0);
        chk("hold_grant_id", int'(grant_id), 0);
        chk("hold_rdata0", int'(rdata0), 8'h14);
        chk("hold_rdata1", int'(rdata1), 8'h12);
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
